ddr4_cmd_scheduler: RTL and testbench

//  Single-requester DDR4 command sequencer for the dimm model.

---
 rtl/ddr4_cmd_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_ddr4_cmd_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_cmd_scheduler.sv
// ddr4_cmd_scheduler: single-requester DDR4 command sequencer. Turns one
// read/write request at a time into PRE/ACT/RD/WR on the dimm pins, keeps a
// per-bank open-row table and enforces tRCD/tRP/tRAS per bank and tCCD globally.
module ddr4_cmd_scheduler #(
    parameter int unsigned BGWIDTH   = 2,
    parameter int unsigned BAWIDTH   = 2,
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned COLWIDTH  = 10,
    parameter int unsigned TW        = 5,
    parameter int unsigned tRCD      = 4,
    parameter int unsigned tRP       = 4,
    parameter int unsigned tRAS      = 10,
    parameter int unsigned tCCD      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic                 cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic                 done_valid,
    output logic                 done_write
);

    localparam int unsigned BIDW  = BGWIDTH + BAWIDTH;
    localparam int unsigned NBANK = 1 << BIDW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROUTE,
        S_PRE,
        S_ACT,
        S_COL
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_PRE,
        CMD_ACT,
        CMD_COL
    } cmd_t;

    state_t state, state_next;
    cmd_t   cmd_c;
    logic   issue_pre_c, issue_act_c, issue_col_c;
    logic   accept_c;

    logic                 lat_write;
    logic [BGWIDTH-1:0]   lat_bg;
    logic [BAWIDTH-1:0]   lat_ba;
    logic [ADDRWIDTH-1:0] lat_row;
    logic [COLWIDTH-1:0]  lat_col;
    logic [BIDW-1:0]      bidx_c;

    logic                 bank_open [NBANK];
    logic [ADDRWIDTH-1:0] bank_row  [NBANK];
    logic [TW-1:0]        ras_cnt   [NBANK];
    logic [TW-1:0]        rp_cnt    [NBANK];
    logic [TW-1:0]        rcd_cnt   [NBANK];
    logic [TW-1:0]        ccd_cnt;

    logic [ADDRWIDTH-1:0] pre_addr_c;
    logic [ADDRWIDTH-1:0] col_addr_c;

    assign bidx_c   = {lat_bg, lat_ba};
    assign accept_c = req_valid && req_ready;

    // Address-pin images for PRE (single bank) and RD/WR of the latched request.
    always_comb begin
        pre_addr_c        = '0;
        pre_addr_c[16:14] = 3'b010;
        pre_addr_c[10]    = 1'b0;
        col_addr_c        = '0;
        col_addr_c[16:14] = lat_write ? 3'b100 : 3'b101;
        col_addr_c[COLWIDTH-1:0] = lat_col;
        col_addr_c[10]    = 1'b0;
    end

    // Next-state and issue decision; a command is registered onto the pins the
    // cycle its timers read zero, so ROUTE can already issue the first command.
    always_comb begin
        state_next  = state;
        cmd_c       = CMD_NONE;
        issue_pre_c = 1'b0;
        issue_act_c = 1'b0;
        issue_col_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept_c) state_next = S_ROUTE;
            end
            S_ROUTE: begin
                if (!bank_open[bidx_c])                 cmd_c = CMD_ACT;
                else if (bank_row[bidx_c] == lat_row)   cmd_c = CMD_COL;
                else                                    cmd_c = CMD_PRE;
            end
            S_PRE:   cmd_c = CMD_PRE;
            S_ACT:   cmd_c = CMD_ACT;
            S_COL:   cmd_c = CMD_COL;
            default: state_next = S_IDLE;
        endcase
        case (cmd_c)
            CMD_PRE: begin
                issue_pre_c = (ras_cnt[bidx_c] == '0);
                state_next  = issue_pre_c ? S_ACT : S_PRE;
            end
            CMD_ACT: begin
                issue_act_c = (rp_cnt[bidx_c] == '0);
                state_next  = issue_act_c ? S_COL : S_ACT;
            end
            CMD_COL: begin
                issue_col_c = (rcd_cnt[bidx_c] == '0) && (ccd_cnt == '0);
                state_next  = issue_col_c ? S_IDLE : S_COL;
            end
            default: ;
        endcase
    end

    // FSM state register and the ready flag that mirrors IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
        end else begin
            state     <= state_next;
            req_ready <= (state_next == S_IDLE);
        end
    end

    // Request latch captured on the accepting handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_write <= 1'b0;
            lat_bg    <= '0;
            lat_ba    <= '0;
            lat_row   <= '0;
            lat_col   <= '0;
        end else if (state == S_IDLE && accept_c) begin
            lat_write <= req_write;
            lat_bg    <= req_bg;
            lat_ba    <= req_ba;
            lat_row   <= req_row;
            lat_col   <= req_col;
        end
    end

    // Open-row table and timing counters; loads hold tX-1 so zero means the
    // next dependent command may be registered for the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NBANK); i++) begin
                bank_open[i] <= 1'b0;
                bank_row[i]  <= '0;
                ras_cnt[i]   <= '0;
                rp_cnt[i]    <= '0;
                rcd_cnt[i]   <= '0;
            end
            ccd_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(NBANK); i++) begin
                if (ras_cnt[i] != '0) ras_cnt[i] <= ras_cnt[i] - TW'(1);
                if (rp_cnt[i]  != '0) rp_cnt[i]  <= rp_cnt[i]  - TW'(1);
                if (rcd_cnt[i] != '0) rcd_cnt[i] <= rcd_cnt[i] - TW'(1);
            end
            if (ccd_cnt != '0) ccd_cnt <= ccd_cnt - TW'(1);
            if (issue_pre_c) begin
                bank_open[bidx_c] <= 1'b0;
                rp_cnt[bidx_c]    <= TW'(tRP - 1);
            end
            if (issue_act_c) begin
                bank_open[bidx_c] <= 1'b1;
                bank_row[bidx_c]  <= lat_row;
                rcd_cnt[bidx_c]   <= TW'(tRCD - 1);
                ras_cnt[bidx_c]   <= TW'(tRAS - 1);
            end
            if (issue_col_c) begin
                ccd_cnt <= TW'(tCCD - 1);
            end
        end
    end

    // Registered dimm pins and completion pulse; idle cycles drive a deselect.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_n       <= 1'b1;
            act_n      <= 1'b1;
            A          <= '0;
            bg         <= '0;
            ba         <= '0;
            done_valid <= 1'b0;
            done_write <= 1'b0;
        end else begin
            cs_n       <= 1'b1;
            act_n      <= 1'b1;
            A          <= '0;
            done_valid <= 1'b0;
            if (issue_pre_c) begin
                cs_n <= 1'b0;
                A    <= pre_addr_c;
                bg   <= lat_bg;
                ba   <= lat_ba;
            end
            if (issue_act_c) begin
                cs_n  <= 1'b0;
                act_n <= 1'b0;
                A     <= lat_row;
                bg    <= lat_bg;
                ba    <= lat_ba;
            end
            if (issue_col_c) begin
                cs_n       <= 1'b0;
                A          <= col_addr_c;
                bg         <= lat_bg;
                ba         <= lat_ba;
                done_valid <= 1'b1;
                done_write <= lat_write;
            end
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Scoreboard bench for ddr4_cmd_scheduler: expected pin commands (with their
// issue cycle) are queued when a request is accepted and popped by a monitor.
module tb_ddr4_cmd_scheduler;

    localparam int unsigned BGW = 2;
    localparam int unsigned BAW = 2;
    localparam int unsigned AW  = 17;
    localparam int unsigned CW  = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid, req_ready, req_write;
    logic [BGW-1:0] req_bg;
    logic [BAW-1:0] req_ba;
    logic [AW-1:0]  req_row;
    logic [CW-1:0]  req_col;
    logic           cs_n, act_n, done_valid, done_write;
    logic [AW-1:0]  A;
    logic [BGW-1:0] bg;
    logic [BAW-1:0] ba;

    logic           r6_valid, r6_ready, r6_write;
    logic [BGW-1:0] r6_bg;
    logic [BAW-1:0] r6_ba;
    logic [AW-1:0]  r6_row;
    logic [CW-1:0]  r6_col;
    logic           r6_cs_n, r6_act_n, r6_done_valid, r6_done_write;
    logic [AW-1:0]  r6_A;
    logic [BGW-1:0] r6_bg_o;
    logic [BAW-1:0] r6_ba_o;

    typedef struct {
        int             cyc;
        logic           act_n;
        logic [AW-1:0]  a;
        logic [BGW-1:0] bg;
        logic [BAW-1:0] ba;
        logic           done;
        logic           dw;
    } exp_t;

    exp_t exp_q[$];
    int   d6q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic started = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ddr4_cmd_scheduler u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba),
        .done_valid(done_valid), .done_write(done_write)
    );

    ddr4_cmd_scheduler #(.tCCD(6)) u_dut6 (
        .clk(clk), .reset(reset),
        .req_valid(r6_valid), .req_ready(r6_ready), .req_write(r6_write),
        .req_bg(r6_bg), .req_ba(r6_ba), .req_row(r6_row), .req_col(r6_col),
        .cs_n(r6_cs_n), .act_n(r6_act_n), .A(r6_A), .bg(r6_bg_o), .ba(r6_ba_o),
        .done_valid(r6_done_valid), .done_write(r6_done_write)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [AW-1:0] col_a(input logic w, input logic [CW-1:0] col);
        logic [AW-1:0] a;
        a        = '0;
        a[16:14] = w ? 3'b100 : 3'b101;
        a[9:0]   = col;
        return a;
    endfunction

    function automatic logic [AW-1:0] pre_a();
        logic [AW-1:0] a;
        a        = '0;
        a[16:14] = 3'b010;
        return a;
    endfunction

    task automatic push(input int c, input logic an, input logic [AW-1:0] a,
                        input logic [BGW-1:0] g, input logic [BAW-1:0] b,
                        input logic dn, input logic w);
        exp_t e;
        e.cyc = c; e.act_n = an; e.a = a; e.bg = g; e.ba = b; e.done = dn; e.dw = w;
        exp_q.push_back(e);
    endtask

    // Monitor: every command must match the head of the queue, idle cycles must be clean.
    always @(negedge clk) begin
        if (started) begin
            if (!cs_n) begin
                check("cmd_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("cmd_cycle", 64'(cyc), 64'(e.cyc));
                    check("cmd_act_n", 64'(act_n), 64'(e.act_n));
                    check("cmd_A", 64'(A), 64'(e.a));
                    check("cmd_bg", 64'(bg), 64'(e.bg));
                    check("cmd_ba", 64'(ba), 64'(e.ba));
                    check("done_valid", 64'(done_valid), 64'(e.done));
                    if (e.done) check("done_write", 64'(done_write), 64'(e.dw));
                end
            end else begin
                check("idle_pins", 64'({act_n, A, done_valid}), 64'({1'b1, 17'h0, 1'b0}));
            end
        end
    end

    always @(negedge clk) begin
        if (started && r6_done_valid) d6q.push_back(cyc);
    end

    task automatic send(input logic w, input logic [BGW-1:0] g, input logic [BAW-1:0] b,
                        input logic [AW-1:0] row, input logic [CW-1:0] col, output int t);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_bg = g; req_ba = b; req_row = row; req_col = col;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept", 64'(req_ready), 64'(1));
        t = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_bg    = BGW'($urandom);
        req_ba    = BAW'($urandom);
        req_row   = AW'($urandom);
        req_col   = CW'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int t, act1, act00, pre_c, act_c;
        logic           w;
        logic [CW-1:0]  col;
        int n;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_bg = '0; req_ba = '0;
        req_row = '0; req_col = '0;
        r6_valid = 1'b0; r6_write = 1'b0; r6_bg = 2'd3; r6_ba = 2'd1; r6_row = 17'h1AB; r6_col = 10'h2;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", 64'(cs_n), 64'(1));
        check("rst_act_n", 64'(act_n), 64'(1));
        check("rst_A", 64'(A), 64'(0));
        check("rst_bg_ba", 64'({bg, ba}), 64'(0));
        check("rst_done", 64'({done_valid, done_write}), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
        started = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Closed-bank read.
        send(1'b0, 2'd1, 2'd2, 17'h0123, 10'h045, t);
        act1 = t + 2;
        push(act1, 1'b0, 17'h0123, 2'd1, 2'd2, 1'b0, 1'b0);
        push(t + 6, 1'b1, col_a(1'b0, 10'h045), 2'd1, 2'd2, 1'b1, 1'b0);
        drain();

        // Row conflict on the same bank.
        send(1'b0, 2'd1, 2'd2, 17'h0200, 10'h033, t);
        pre_c = (t + 2 > act1 + 10) ? t + 2 : act1 + 10;
        act_c = pre_c + 4;
        push(pre_c, 1'b1, pre_a(), 2'd1, 2'd2, 1'b0, 1'b0);
        push(act_c, 1'b0, 17'h0200, 2'd1, 2'd2, 1'b0, 1'b0);
        push(act_c + 4, 1'b1, col_a(1'b0, 10'h033), 2'd1, 2'd2, 1'b1, 1'b0);
        drain();

        // Row hit write.
        send(1'b1, 2'd1, 2'd2, 17'h0200, 10'h010, t);
        push(t + 2, 1'b1, col_a(1'b1, 10'h010), 2'd1, 2'd2, 1'b1, 1'b1);
        drain();

        // Bank (0,0): open, then conflict; then closed bank (0,1) right after.
        send(1'b0, 2'd0, 2'd0, 17'h0005, 10'h001, t);
        act00 = t + 2;
        push(act00, 1'b0, 17'h0005, 2'd0, 2'd0, 1'b0, 1'b0);
        push(t + 6, 1'b1, col_a(1'b0, 10'h001), 2'd0, 2'd0, 1'b1, 1'b0);
        drain();
        send(1'b0, 2'd0, 2'd0, 17'h0006, 10'h002, t);
        pre_c = (t + 2 > act00 + 10) ? t + 2 : act00 + 10;
        push(pre_c, 1'b1, pre_a(), 2'd0, 2'd0, 1'b0, 1'b0);
        push(pre_c + 4, 1'b0, 17'h0006, 2'd0, 2'd0, 1'b0, 1'b0);
        push(pre_c + 8, 1'b1, col_a(1'b0, 10'h002), 2'd0, 2'd0, 1'b1, 1'b0);
        drain();
        send(1'b0, 2'd0, 2'd1, 17'h0007, 10'h003, t);
        push(t + 2, 1'b0, 17'h0007, 2'd0, 2'd1, 1'b0, 1'b0);
        push(t + 6, 1'b1, col_a(1'b0, 10'h003), 2'd0, 2'd1, 1'b1, 1'b0);
        drain();

        // Random hits to the open row of (0,1).
        for (int i = 0; i < 4; i++) begin
            w   = 1'($urandom_range(0, 1));
            col = CW'($urandom_range(0, 1023));
            send(w, 2'd0, 2'd1, 17'h0007, col, t);
            push(t + 2, 1'b1, col_a(w, col), 2'd0, 2'd1, 1'b1, w);
            drain();
        end

        // Reset the cycle after a miss's ACT: request abandoned, table cleared.
        send(1'b0, 2'd2, 2'd3, 17'h0077, 10'h3FF, t);
        push(t + 2, 1'b0, 17'h0077, 2'd2, 2'd3, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_cs_n", 64'(cs_n), 64'(1));
            check("rst_mid_done", 64'(done_valid), 64'(0));
        end
        check("rst_mid_ready", 64'(req_ready), 64'(0));
        check("rst_mid_queue", 64'(exp_q.size()), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        send(1'b0, 2'd2, 2'd3, 17'h0077, 10'h3FF, t);
        push(t + 2, 1'b0, 17'h0077, 2'd2, 2'd3, 1'b0, 1'b0);
        push(t + 6, 1'b1, col_a(1'b0, 10'h3FF), 2'd2, 2'd3, 1'b1, 1'b0);
        drain();

        // tCCD=6 instance: continuous requests to one row, reads 6 cycles apart.
        @(posedge clk); #1;
        r6_valid = 1'b1;
        n = 0;
        while (d6q.size() < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        r6_valid = 1'b0;
        check("ccd_done_count", 64'(d6q.size() >= 3), 64'(1));
        if (d6q.size() >= 3) begin
            check("ccd_gap_1", 64'(d6q[1] - d6q[0]), 64'(6));
            check("ccd_gap_2", 64'(d6q[2] - d6q[1]), 64'(6));
        end

        repeat (20) @(negedge clk);
        check("final_queue", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
